// File: rtl/spi_arbiter.sv
// Two-requester arbiter in front of a single SPI master: grants one requester at a
// time, strobes the word into the master, and waits for its output-valid rise or a timeout.
module spi_arbiter #(
  parameter int N       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] data0,
  input  logic [N-1:0] data1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic [N-1:0] rx_data,
  output logic         err,
  output logic         busy,
  output logic [1:0]   cs_n,
  output logic         spi_load,
  output logic [N-1:0] spi_data,
  input  logic         spi_en_out,
  input  logic [N-1:0] spi_rx
);

  typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

  localparam logic [9:0] LOAD_LAST = 10'd3;
  localparam logic [9:0] XFER_LAST = 10'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [9:0] cnt;
  logic       winner;
  logic       last_served;
  logic       timed_out;
  logic       en_prev;
  logic       grant_any;
  logic       grant_sel;
  logic       en_rise;
  logic       xfer_timeout;

  // Round-robin between the two requesters; last_served resets to 1 so requester 0 goes first.
  always_comb begin
    grant_any = req0 | req1;
    grant_sel = 1'b0;
    if (req0 && req1) begin
      grant_sel = ~last_served;
    end else begin
      grant_sel = req1;
    end
  end

  assign en_rise      = spi_en_out & ~en_prev;
  assign xfer_timeout = (cnt == XFER_LAST);

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err       = 1'b0;
    spi_load  = 1'b0;
    cs_n      = 2'b11;
    case (state)
      IDLE: begin
        // Grant is combinational on the request levels, so it is masked while reset is held.
        if (grant_any && !rst) begin
          state_nxt = LOAD;
          gnt0      = ~grant_sel;
          gnt1      = grant_sel;
        end
      end
      LOAD: begin
        spi_load = 1'b1;
        cs_n     = winner ? 2'b01 : 2'b10;
        if (cnt == LOAD_LAST) begin
          state_nxt = XFER;
        end
      end
      XFER: begin
        cs_n = winner ? 2'b01 : 2'b10;
        if (en_rise || xfer_timeout) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done0     = ~winner;
        done1     = winner;
        err       = timed_out;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      en_prev <= 1'b0;
    end else begin
      state   <= state_nxt;
      en_prev <= spi_en_out;
      if ((state_nxt != state) || (state == IDLE) || (state == DONE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 10'd1;
      end
    end
  end

  // A rise in the timeout cycle still counts as a successful capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner      <= 1'b0;
      last_served <= 1'b1;
      timed_out   <= 1'b0;
      spi_data    <= '0;
      rx_data     <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        winner      <= grant_sel;
        last_served <= grant_sel;
        spi_data    <= grant_sel ? data1 : data0;
        timed_out   <= 1'b0;
      end
      if (state == XFER) begin
        if (en_rise) begin
          rx_data   <= spi_rx;
          timed_out <= 1'b0;
        end else if (xfer_timeout) begin
          rx_data   <= '0;
          timed_out <= 1'b1;
        end
      end
    end
  end

endmodule
